// File: rtl/acumulador_pkg.sv
// Shared definitions for the checkout accumulator: FSM encoding, tax constants
// and the fim_compra-to-receipt latency helper.
package acumulador_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCUM   = 3'd1,
    ST_MULT    = 3'd2,
    ST_DIV     = 3'd3,
    ST_RECEIPT = 3'd4
  } state_t;

  localparam int unsigned TAX_DIVISOR  = 32'd100;
  localparam int unsigned TAX_MAX      = 32'd100;
  localparam int unsigned MULT_EXTRA_W = 32'd8;

  // Counts the MULT cycle, the N division steps and the RECEIPT entry cycle.
  function automatic int unsigned TAX_LATENCY(input int unsigned price_w);
    return price_w + MULT_EXTRA_W + 32'd2;
  endfunction

endpackage

// File: rtl/divisor_seq.sv
// Restoring divider by the fixed TAX_DIVISOR; one quotient bit per cycle, N cycles.
// done is raised during the last step and quotient carries that step's result.
module divisor_seq
  import acumulador_pkg::*;
#(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient
);

  localparam int REM_W = $clog2(TAX_DIVISOR) + 1;
  localparam int CNT_W = $clog2(N + 1);

  logic [N-1:0]     q_q, q_d;
  logic [REM_W-1:0] rem_q, rem_d, trial_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             last_s;

  assign last_s = busy_q && (cnt_q == CNT_W'(N - 1));

  // q_q starts as the dividend and shifts left, collecting quotient bits at the bottom.
  always_comb begin
    trial_s = {rem_q[REM_W-2:0], q_q[N-1]};
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (busy_q) begin
      if (trial_s >= REM_W'(TAX_DIVISOR)) begin
        rem_d = trial_s - REM_W'(TAX_DIVISOR);
        q_d   = {q_q[N-2:0], 1'b1};
      end else begin
        rem_d = trial_s;
        q_d   = {q_q[N-2:0], 1'b0};
      end
      if (last_s) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (start) begin
      q_d    = dividend;
      rem_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = last_s;
  assign quotient = q_d;

endmodule

// File: rtl/acumulador_compra.sv
// Checkout accumulator: saturating price/weight totals with void support, item
// count, optional percentage tax through a sequential divider, receipt hold until ack.
module acumulador_compra
  import acumulador_pkg::*;
#(
  parameter int PRICE_W  = 16,
  parameter int WEIGHT_W = 16,
  parameter int COUNT_W  = 8,
  parameter int TAX_W    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                item_valid,
  output logic                item_ready,
  input  logic                item_void,
  input  logic [PRICE_W-1:0]  preco_produto,
  input  logic [WEIGHT_W-1:0] peso_produto,
  input  logic                fim_compra,
  input  logic                taxa,
  input  logic [TAX_W-1:0]    taxa_pct,
  input  logic                talao_ack,
  output logic [PRICE_W-1:0]  soma_final,
  output logic [WEIGHT_W-1:0] soma_peso,
  output logic [COUNT_W-1:0]  num_itens,
  output logic                emissao_talao,
  output logic [TAX_W-1:0]    valor_taxa,
  output logic                overflow,
  output logic                erro_void
);

  localparam int N = PRICE_W + MULT_EXTRA_W;

  state_t              state_q, state_d;
  logic [PRICE_W-1:0]  soma_final_q, soma_final_d;
  logic [WEIGHT_W-1:0] soma_peso_q, soma_peso_d;
  logic [COUNT_W-1:0]  num_itens_q, num_itens_d;
  logic [TAX_W-1:0]    valor_taxa_q, valor_taxa_d;
  logic                overflow_q, overflow_d;
  logic                erro_void_q, erro_void_d;

  logic [PRICE_W:0]          price_sum_s;
  logic [WEIGHT_W:0]         weight_sum_s;
  logic [MULT_EXTRA_W-1:0]   factor_s;
  logic [N-1:0]              product_s, quotient_s;
  logic [TAX_W-1:0]          taxa_sat_s;
  logic                      void_ok_s, div_start_s, div_busy_s, div_done_s;

  assign price_sum_s  = {1'b0, soma_final_q} + {1'b0, preco_produto};
  assign weight_sum_s = {1'b0, soma_peso_q} + {1'b0, peso_produto};
  assign void_ok_s    = (num_itens_q != '0) && (preco_produto <= soma_final_q)
                        && (peso_produto <= soma_peso_q);
  assign taxa_sat_s   = (taxa_pct > TAX_W'(TAX_MAX)) ? TAX_W'(TAX_MAX) : taxa_pct;
  assign factor_s     = MULT_EXTRA_W'(TAX_DIVISOR) + MULT_EXTRA_W'(valor_taxa_q);
  assign product_s    = N'(soma_final_q) * N'(factor_s);

  divisor_seq #(.N(N)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_s),
    .dividend (product_s),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quotient (quotient_s)
  );

  // Next-state logic; a same-cycle item is folded in before fim_compra is acted on.
  always_comb begin
    state_d      = state_q;
    soma_final_d = soma_final_q;
    soma_peso_d  = soma_peso_q;
    num_itens_d  = num_itens_q;
    valor_taxa_d = valor_taxa_q;
    overflow_d   = overflow_q;
    erro_void_d  = 1'b0;
    div_start_s  = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (item_valid && item_void) begin
          if (void_ok_s) begin
            soma_final_d = soma_final_q - preco_produto;
            soma_peso_d  = soma_peso_q - peso_produto;
            num_itens_d  = num_itens_q - COUNT_W'(1);
          end else begin
            erro_void_d = 1'b1;
          end
        end else if (item_valid) begin
          soma_final_d = price_sum_s[PRICE_W] ? {PRICE_W{1'b1}} : price_sum_s[PRICE_W-1:0];
          soma_peso_d  = weight_sum_s[WEIGHT_W] ? {WEIGHT_W{1'b1}} : weight_sum_s[WEIGHT_W-1:0];
          overflow_d   = overflow_q | price_sum_s[PRICE_W] | weight_sum_s[WEIGHT_W];
          if (num_itens_q != {COUNT_W{1'b1}}) begin
            num_itens_d = num_itens_q + COUNT_W'(1);
          end else begin
            num_itens_d = num_itens_q;
          end
          state_d = ST_ACCUM;
        end else begin
          state_d = state_q;
        end
        if (fim_compra && (state_q == ST_ACCUM)) begin
          if (taxa) begin
            valor_taxa_d = taxa_sat_s;
            state_d      = ST_MULT;
          end else begin
            valor_taxa_d = '0;
            state_d      = ST_RECEIPT;
          end
        end else begin
          valor_taxa_d = valor_taxa_q;
        end
      end
      ST_MULT: begin
        div_start_s = !div_busy_s;
        state_d     = ST_DIV;
      end
      ST_DIV: begin
        if (div_done_s) begin
          if (|quotient_s[N-1:PRICE_W]) begin
            soma_final_d = {PRICE_W{1'b1}};
            overflow_d   = 1'b1;
          end else begin
            soma_final_d = quotient_s[PRICE_W-1:0];
          end
          state_d = ST_RECEIPT;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_RECEIPT: begin
        if (talao_ack) begin
          soma_final_d = '0;
          soma_peso_d  = '0;
          num_itens_d  = '0;
          valor_taxa_d = '0;
          overflow_d   = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RECEIPT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      soma_final_q <= '0;
      soma_peso_q  <= '0;
      num_itens_q  <= '0;
      valor_taxa_q <= '0;
      overflow_q   <= 1'b0;
      erro_void_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      soma_final_q <= soma_final_d;
      soma_peso_q  <= soma_peso_d;
      num_itens_q  <= num_itens_d;
      valor_taxa_q <= valor_taxa_d;
      overflow_q   <= overflow_d;
      erro_void_q  <= erro_void_d;
    end
  end

  assign item_ready    = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign emissao_talao = (state_q == ST_RECEIPT);
  assign soma_final    = soma_final_q;
  assign soma_peso     = soma_peso_q;
  assign num_itens     = num_itens_q;
  assign valor_taxa    = valor_taxa_q;
  assign overflow      = overflow_q;
  assign erro_void     = erro_void_q;

endmodule

// File: doc/acumulador_compra.md
Name: acumulador_compra

Overview:
- Parametrised checkout accumulator for the supermarket scale; successor to the fixed 11-bit price/weight summer.
- Accepts priced/weighed items over a valid/ready handshake, supports item removal (void), counts items, and saturates on overflow.
- On end of purchase, applies a runtime-selectable tax percentage using a multi-cycle divider, then holds the receipt until it is acknowledged.
- Sits between the price calculator and the receipt/display logic.

Parameters:
- PRICE_W, 16, width of price inputs and of the price total.
- WEIGHT_W, 16, width of weight inputs and of the weight total.
- COUNT_W, 8, width of the item counter.
- TAX_W, 7, width of the tax-percentage input and indication.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- item_valid  in  1  item present on preco_produto/peso_produto.
- item_ready  out  1  item accepted this cycle if item_valid is also high.
- item_void  in  1  qualifies item_valid: 1 means remove the item, 0 means add it.
- preco_produto  in  PRICE_W  item price.
- peso_produto  in  WEIGHT_W  item weight.
- fim_compra  in  1  end-of-purchase request.
- taxa  in  1  apply tax; sampled together with fim_compra.
- taxa_pct  in  TAX_W  tax percentage; sampled together with fim_compra.
- talao_ack  in  1  receipt consumed.
- soma_final  out  PRICE_W  accumulated price (tax included once in RECEIPT).
- soma_peso  out  WEIGHT_W  accumulated weight.
- num_itens  out  COUNT_W  number of items currently in the purchase.
- emissao_talao  out  1  receipt valid.
- valor_taxa  out  TAX_W  tax percentage actually applied.
- overflow  out  1  sticky: some total saturated or the taxed result was clamped.
- erro_void  out  1  one-cycle pulse when a void is rejected.

Behaviour:
- Reset: all outputs 0, FSM enters IDLE. The divider is aborted, even mid-operation.

FSM states: IDLE, ACCUM, MULT, DIV, RECEIPT.
- item_ready is 1 in IDLE and ACCUM, 0 elsewhere.
- An item is accepted when item_valid && item_ready.

Add (item_void=0):
- soma_final += preco_produto and soma_peso += peso_produto, each saturating at its all-ones maximum.
- Any saturation sets overflow.
- num_itens increments, saturating at its maximum.
- IDLE moves to ACCUM.

Void (item_void=1):
- Rejected if num_itens==0, preco_produto>soma_final, or peso_produto>soma_peso.
- On rejection: no state change and erro_void=1 for one cycle.
- Otherwise both totals are decremented and num_itens decrements. The FSM stays in ACCUM, even when the count reaches 0.

fim_compra handling:
- Ignored in IDLE; any simultaneous item is still accepted.
- In ACCUM at cycle t: any simultaneous item is accepted first and is included in the total. taxa and taxa_pct are sampled at t.
- taxa=0: valor_taxa=0, go to RECEIPT; emissao_talao=1 at t+1.
- taxa=1: valor_taxa=min(taxa_pct,100), go to MULT.
  - MULT (one cycle): registers P = soma_final*(100+valor_taxa), width N=PRICE_W+8.
  - DIV: restoring division of P by 100, taking N cycles with truncation. Quotient > 2^PRICE_W-1 is clamped to all-ones and sets overflow.
  - soma_final is updated on entry to RECEIPT. emissao_talao=1 at t+N+2 (t+26 at defaults).
- soma_peso and num_itens are never taxed.

RECEIPT:
- Outputs are held and items are ignored.
- talao_ack clears soma_final, soma_peso, num_itens, valor_taxa and overflow, and returns to IDLE. emissao_talao drops the next cycle.
- talao_ack outside RECEIPT is ignored.
- fim_compra in MULT, DIV or RECEIPT is ignored.

Decomposition:
- Shared package acumulador_pkg holds:
  - FSM state encoding.
  - Constants TAX_DIVISOR=100, TAX_MAX=100, MULT_EXTRA_W=8.
  - Latency helper TAX_LATENCY(PRICE_W)=PRICE_W+10, i.e. fim_compra to emissao_talao; this includes the MULT cycle and the RECEIPT entry cycle.
- One sub-module, divisor_seq: a parametrised restoring divider with ports start, busy, done, dividend and quotient. The divisor is fixed to TAX_DIVISOR and the division completes in N cycles.

Test Plan:
- Add 250/300 and 120/150, then fim_compra with taxa=0 -> at t+1: emissao_talao=1, soma_final=370, soma_peso=450, num_itens=2, valor_taxa=0.
- Same two items, taxa=1, taxa_pct=27 -> at t+26: emissao_talao=1, soma_final=469 (46990/100), soma_peso=450, valor_taxa=27; taxa_pct=120 -> valor_taxa=100, soma_final=740.
- Add 250/300, void 250/300 -> totals 0, num_itens=0; void 1/1 again -> erro_void pulses once, nothing changes.
- Add 60000 then 10000 -> soma_final=65535, overflow=1; tax 27% -> soma_final stays 65535, overflow stays 1.
- item_valid (100/50) together with fim_compra, taxa=0 -> the item is included in the receipt. Assert rst during DIV -> all outputs 0 and IDLE next cycle.
- In RECEIPT, drive item_valid and fim_compra -> item_ready=0, no change; talao_ack -> the cycle after, all outputs 0 and item_ready=1.
